// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

  // Access size codes as presented on the size input
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte lane 0 carries bits 7:0 of the memory word
  localparam bit LITTLE_ENDIAN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // A request that cannot be served as a single aligned word access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Byte enables for the addressed field within the aligned word
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the narrow store field into every lane it could land in
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extract.sv
// Selects the addressed byte/halfword of a memory word and extends it to 32 bits.
// Latency: purely combinational.
// Backpressure: none.
module load_extract
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  // Lane select followed by sign/zero fill of the upper bits
  always_comb begin
    byte_sel = 8'h00;
    half_sel = lane_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    fill     = 1'b0;
    ext_o    = mem_rdata_i;
    case (lane_i)
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    case (size_i)
      SZ_BYTE: begin
        fill  = ~is_unsigned_i & byte_sel[7];
        ext_o = {{24{fill}}, byte_sel};
      end
      SZ_HALF: begin
        fill  = ~is_unsigned_i & half_sel[15];
        ext_o = {{16{fill}}, half_sel};
      end
      default: ext_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: narrows stores into byte lanes, extends loads, req/ack to memory.
// Latency: accept T0, mem_req from T1, ack at T1+k, done at T2+k; misaligned done at T1.
// Backpressure: start is only sampled when idle; mem_req held until mem_ack or timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  // Wait counter only needs to reach TIMEOUT-1; the abort fires on that cycle
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       load_val;

  load_extract u_extract (
    .mem_rdata_i   (mem_rdata),
    .lane_i        (lane_q),
    .size_i        (size_q),
    .is_unsigned_i (uns_q),
    .ext_o         (load_val)
  );

  assign rdata       = rdata_q;
  assign misaligned  = mis_q;
  assign timeout_err = tmo_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    tmo_d   = tmo_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_RESP);
    mem_req = (state_q == ST_REQ);
    mem_we  = (state_q == ST_REQ) & store_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          store_d = is_store;
          size_d  = size;
          uns_d   = is_unsigned;
          lane_d  = addr[1:0];
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          be_d    = byte_enables(size, addr[1:0]);
          wdata_d = lane_replicate(size, wdata);
          cnt_d   = '0;
          tmo_d   = 1'b0;
          mis_d   = is_misaligned(size, addr[1:0]);
          state_d = is_misaligned(size, addr[1:0]) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          // Ack beats a simultaneous timeout
          if (!store_q) rdata_d = load_val;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a behavioural memory responder.
// Latency: checks done timing against accept time for every transaction.
// Backpressure: drives start only when idle, plus deliberate pokes while busy.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        is_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, timeout_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misaligned(misaligned), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          mis;
    bit          tmo;
    logic [31:0] rdata;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Expected memory-side view of the transaction in flight
  logic [31:0] cur_addr = 32'h0;
  logic [3:0]  cur_be = 4'h0;
  logic [31:0] cur_wdata = 32'h0;
  bit          cur_we = 1'b0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = 32'h0;
  int          req_seen = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;
  logic [31:0] model_rdata = 32'h0;

  // Reference extraction: shift, mask, then fill from the field MSB
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input bit uns);
    int          bits;
    int          shift;
    logic [31:0] mask;
    logic [31:0] f;
    if (sz == 2'd2) return w;
    bits  = (sz == 2'd0) ? 8 : 16;
    shift = (sz == 2'd0) ? 8 * int'(off) : (off[1] ? 16 : 0);
    mask  = (32'h1 << bits) - 32'h1;
    f     = (w >> shift) & mask;
    if (!uns && f[bits-1]) f = f | ~mask;
    return f;
  endfunction

  // Memory responder: checks request stability and acks after cur_delay wait cycles
  always @(negedge clk) begin
    if (mem_req) begin
      chk("mem_addr", mem_addr, cur_addr);
      chk("mem_be", {28'h0, mem_be}, {28'h0, cur_be});
      chk("mem_we", {31'h0, mem_we}, {31'h0, cur_we});
      if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
      if (req_seen == cur_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = cur_rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      req_seen++;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("misaligned", {31'h0, misaligned}, {31'h0, mon_e.mis});
        chk("timeout_err", {31'h0, timeout_err}, {31'h0, mon_e.tmo});
        chk("rdata", rdata, mon_e.rdata);
        chk("done_latency", 32'(cyc - acc_cyc + 1), 32'(mon_e.lat));
        chk("req_cycles", 32'(req_seen), 32'(mon_e.reqs));
        chk("busy_on_done", {31'h0, busy}, 32'h1);
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=%0b pending=%0d expected idle", busy, sb.size());
      sb.delete();
    end
  endtask

  // Issue one request; the expected outcome comes from the access rules directly
  task automatic issue(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly,
                       input bit poke, input bit expect_done);
    exp_t        e;
    logic [1:0]  off;
    bit          mis, timed;
    wait_idle();
    off   = a[1:0];
    mis   = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0) || (sz == 2'd3);
    timed = !mis && (dly >= TMO);
    if (!mis && !timed && !st) model_rdata = extract(rd, off, sz, uns);
    e.mis   = mis;
    e.tmo   = timed;
    e.rdata = model_rdata;
    e.reqs  = mis ? 0 : (timed ? TMO : dly + 1);
    e.lat   = mis ? 1 : (timed ? TMO + 1 : dly + 2);
    cur_addr  = a & 32'hFFFF_FFFC;
    cur_be    = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << (off & 2'd2)) : 4'hF;
    cur_wdata = (sz == 2'd0) ? wd[7:0] * 32'h0101_0101 :
                (sz == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
    cur_we    = st;
    cur_delay = dly;
    cur_rdata = rd;
    req_seen  = 0;
    start = 1'b1; is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    if (poke) begin
      start = 1'b1; is_store = ~st; size = 2'($urandom_range(0, 2));
      addr = $urandom; wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Directed cases
    issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 2, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 1, 1'b0, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h1234_56AB, 32'h0, 0, 1'b0, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h5555_5555, 0, 1'b1, 1'b1);
    issue(1'b0, 2'd3, 1'b1, 32'h0000_0000, 32'h0, 32'h5555_5555, 0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 10, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 32'h2468_ACE0, TMO - 1, 1'b1, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0048, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 1'b1);

    // Reset while the request is outstanding
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hFFFF_FFFF, 100, 1'b0, 1'b0);
    chk("req_before_reset", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_req", {31'h0, mem_req}, 32'h0);
    chk("reset_drops_busy", {31'h0, busy}, 32'h0);
    model_rdata = 32'h0;
    seen = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(seen));
    chk("rdata_after_reset", rdata, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, $urandom, $urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
